// File: rtl/skeleton_host_sequencer_if.sv
// Host-side byte streams and skeleton bus for the host sequencer.
// master: the sequencer; slave: the UART stages and skeleton it connects to.
interface skeleton_host_sequencer_if #(
  parameter int unsigned BITWIDTH_SYS  = 16,
  parameter int unsigned BITWIDTH_ADR  = 6,
  parameter int unsigned BITWIDTH_HEAD = 26
);
  logic [7:0]               RX_DATA;
  logic                     RX_VLD;
  logic                     RX_RDY;
  logic [7:0]               TX_DATA;
  logic                     TX_VLD;
  logic                     TX_RDY;
  logic                     SKEL_EN;
  logic                     SKEL_RNW;
  logic [BITWIDTH_ADR-1:0]  SKEL_ADR;
  logic [BITWIDTH_SYS-1:0]  SKEL_DIN;
  logic                     SKEL_TRGG;
  logic [BITWIDTH_SYS-1:0]  SKEL_DOUT;
  logic [BITWIDTH_HEAD-1:0] SKEL_HEAD;
  logic                     SKEL_RDY;

  modport master (
    input  RX_DATA, RX_VLD, TX_RDY, SKEL_DOUT, SKEL_HEAD, SKEL_RDY,
    output RX_RDY, TX_DATA, TX_VLD, SKEL_EN, SKEL_RNW, SKEL_ADR, SKEL_DIN, SKEL_TRGG
  );

  modport slave (
    output RX_DATA, RX_VLD, TX_RDY, SKEL_DOUT, SKEL_HEAD, SKEL_RDY,
    input  RX_RDY, TX_DATA, TX_VLD, SKEL_EN, SKEL_RNW, SKEL_ADR, SKEL_DIN, SKEL_TRGG
  );
endinterface

// File: rtl/skeleton_host_sequencer.sv
// Byte-stream command sequencer: turns host command bytes into skeleton bus
// cycles (write, start, read, header) and streams results/status back.
module skeleton_host_sequencer #(
  parameter int unsigned BITWIDTH_SYS  = 16,
  parameter int unsigned BITWIDTH_ADR  = 6,
  parameter int unsigned BITWIDTH_HEAD = 26,
  parameter int unsigned TIMEOUT_CYC   = 1024
) (
  input  logic                        CLK_SYS,
  input  logic                        RST,
  skeleton_host_sequencer_if.master   bus
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, WR_MSB, WR_LSB, WR_EXEC, START, WAIT_LO, WAIT_HI,
    RD_SET, RD_CAP, HEAD_LD, TX_SEND
  } state_t;

  state_t                  state_q, state_d;
  logic                    en_q;
  logic [BITWIDTH_ADR-1:0] addr_q;
  logic [15:0]             din_q;
  logic [31:0]             sh_q;
  logic [2:0]              bcnt_q;
  logic [TCNT_W-1:0]       tcnt_q;

  logic       rx_rdy, rnw, trgg, tx_vld;
  logic       ld_status, ld_rd, ld_head, tx_shift;
  logic [7:0] status_byte;
  logic       rx_hs, timeout, in_wait_q, in_wait_d;

  assign rx_hs     = rx_rdy && bus.RX_VLD;
  assign timeout   = (tcnt_q == TCNT_W'(TIMEOUT_CYC));
  assign in_wait_q = (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign in_wait_d = (state_d == WAIT_LO) || (state_d == WAIT_HI);

  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    rx_rdy      = 1'b0;
    rnw         = 1'b1;
    trgg        = 1'b0;
    tx_vld      = 1'b0;
    ld_status   = 1'b0;
    status_byte = '0;
    ld_rd       = 1'b0;
    ld_head     = 1'b0;
    tx_shift    = 1'b0;
    case (state_q)
      IDLE: begin
        // en_q keeps RX_RDY low in the first cycle after reset release
        rx_rdy = en_q;
        if (en_q && bus.RX_VLD) begin
          case (bus.RX_DATA[7:6])
            2'b00:   state_d = WR_MSB;
            2'b01:   state_d = START;
            2'b10:   state_d = RD_SET;
            default: state_d = HEAD_LD;
          endcase
        end
      end
      WR_MSB: begin
        rx_rdy = 1'b1;
        if (bus.RX_VLD) state_d = WR_LSB;
      end
      WR_LSB: begin
        rx_rdy = 1'b1;
        if (bus.RX_VLD) state_d = WR_EXEC;
      end
      WR_EXEC: begin
        rnw     = 1'b0;
        state_d = IDLE;
      end
      START: begin
        if (bus.SKEL_RDY) begin
          trgg    = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (timeout) begin
          ld_status   = 1'b1;
          status_byte = 8'hEE;
          state_d     = TX_SEND;
        end else if (!bus.SKEL_RDY) begin
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.SKEL_RDY) begin
          ld_status   = 1'b1;
          status_byte = 8'h01;
          state_d     = TX_SEND;
        end else if (timeout) begin
          ld_status   = 1'b1;
          status_byte = 8'hEE;
          state_d     = TX_SEND;
        end
      end
      RD_SET:  state_d = RD_CAP;
      RD_CAP: begin
        ld_rd   = 1'b1;
        state_d = TX_SEND;
      end
      HEAD_LD: begin
        ld_head = 1'b1;
        state_d = TX_SEND;
      end
      TX_SEND: begin
        tx_vld = 1'b1;
        if (bus.TX_RDY) begin
          tx_shift = 1'b1;
          if (bcnt_q <= 3'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      sh_q   <= '0;
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      en_q <= 1'b1;
      if (state_q == IDLE && rx_hs) addr_q <= bus.RX_DATA[BITWIDTH_ADR-1:0];
      if (state_q == WR_MSB && rx_hs) din_q[15:8] <= bus.RX_DATA;
      if (state_q == WR_LSB && rx_hs) din_q[7:0]  <= bus.RX_DATA;

      // Counts cycles since the trigger; cleared whenever the wait states are left
      if (trgg)
        tcnt_q <= TCNT_W'(1);
      else if (in_wait_q && in_wait_d) begin
        if (!timeout) tcnt_q <= tcnt_q + TCNT_W'(1);
      end else
        tcnt_q <= '0;

      if (ld_status) begin
        sh_q   <= {status_byte, 24'h0};
        bcnt_q <= 3'd1;
      end else if (ld_rd) begin
        sh_q   <= 32'(bus.SKEL_DOUT) << 16;
        bcnt_q <= 3'd2;
      end else if (ld_head) begin
        sh_q   <= 32'(bus.SKEL_HEAD);
        bcnt_q <= 3'd4;
      end else if (tx_shift) begin
        sh_q <= sh_q << 8;
        if (bcnt_q != 3'd0) bcnt_q <= bcnt_q - 3'd1;
      end
    end
  end

  assign bus.RX_RDY    = rx_rdy;
  assign bus.TX_DATA   = sh_q[31:24];
  assign bus.TX_VLD    = tx_vld;
  assign bus.SKEL_EN   = en_q;
  assign bus.SKEL_RNW  = rnw;
  assign bus.SKEL_ADR  = addr_q;
  assign bus.SKEL_DIN  = BITWIDTH_SYS'(din_q);
  assign bus.SKEL_TRGG = trgg;

endmodule

// File: tb/tb_skeleton_host_sequencer.sv
// Scoreboard bench for skeleton_host_sequencer with a small behavioural
// skeleton (64-word memory, word0 <- word0.msb * word1.msb on trigger).
module tb_skeleton_host_sequencer;
  localparam int unsigned TO = 1024;

  logic CLK_SYS = 1'b0;
  logic RST     = 1'b1;
  always #5 CLK_SYS = ~CLK_SYS;

  skeleton_host_sequencer_if #(.BITWIDTH_SYS(16), .BITWIDTH_ADR(6), .BITWIDTH_HEAD(26)) bus ();

  skeleton_host_sequencer #(
    .BITWIDTH_SYS(16), .BITWIDTH_ADR(6), .BITWIDTH_HEAD(26), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK_SYS(CLK_SYS),
    .RST    (RST),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0]  exp_tx[$];
  logic [21:0] exp_wr[$];

  // skeleton model
  logic [15:0] mem [64];
  int   busy = 0;
  int   cyc  = 0;
  int   trig_cnt = 0;
  int   last_trig_cyc = 0;
  int   last_tx_cyc = 0;
  logic stuck = 1'b0;
  logic signed [15:0] sa, sb, prod;

  assign sa = {{8{mem[0][15]}}, mem[0][15:8]};
  assign sb = {{8{mem[1][15]}}, mem[1][15:8]};
  assign prod = sa * sb;

  assign bus.SKEL_RDY  = stuck || (busy == 0);
  assign bus.SKEL_DOUT = mem[bus.SKEL_ADR];
  assign bus.SKEL_HEAD = 26'h1020510;

  always @(posedge CLK_SYS) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
    end else begin
      if (bus.SKEL_EN && !bus.SKEL_RNW) mem[bus.SKEL_ADR] <= bus.SKEL_DIN;
      if (bus.SKEL_TRGG) begin
        trig_cnt      <= trig_cnt + 1;
        last_trig_cyc <= cyc;
        if (!stuck) busy <= 6;
      end else if (busy > 0) begin
        busy <= busy - 1;
        if (busy == 1) mem[0] <= prod;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // monitor: compares every TX handshake and every write strobe against the queues
  always @(negedge CLK_SYS) begin
    if (!RST && bus.TX_VLD && bus.TX_RDY) begin
      last_tx_cyc = cyc;
      if (exp_tx.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL tx_unexpected: got %0h, required no byte", bus.TX_DATA);
      end else
        check("tx_byte", 32'(bus.TX_DATA), 32'(exp_tx.pop_front()));
    end
    if (!RST && bus.SKEL_EN && !bus.SKEL_RNW) begin
      if (exp_wr.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL wr_unexpected: got adr %0h din %0h, required no strobe",
                 bus.SKEL_ADR, bus.SKEL_DIN);
      end else
        check("wr_strobe", 32'({bus.SKEL_ADR, bus.SKEL_DIN}), 32'(exp_wr.pop_front()));
    end
  end

  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    @(posedge CLK_SYS); #1;
    bus.RX_VLD  = 1'b1;
    bus.RX_DATA = b;
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK_SYS);
      if (bus.RX_RDY) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL rx_accept: got RX_RDY 0 for byte %0h, required 1", b);
    end
    @(posedge CLK_SYS); #1;
    bus.RX_VLD = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK_SYS);
      if (exp_tx.size() == 0 && exp_wr.size() == 0 && !bus.TX_VLD && bus.RX_RDY) begin
        ok = 1'b1; break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d tx / %0d wr outstanding, required 0", name,
               exp_tx.size(), exp_wr.size());
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_rdy"},  32'(bus.RX_RDY),    32'd0);
    check({tag, "_tx_vld"},  32'(bus.TX_VLD),    32'd0);
    check({tag, "_tx_data"}, 32'(bus.TX_DATA),   32'd0);
    check({tag, "_en"},      32'(bus.SKEL_EN),   32'd0);
    check({tag, "_rnw"},     32'(bus.SKEL_RNW),  32'd1);
    check({tag, "_adr"},     32'(bus.SKEL_ADR),  32'd0);
    check({tag, "_din"},     32'(bus.SKEL_DIN),  32'd0);
    check({tag, "_trgg"},    32'(bus.SKEL_TRGG), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.RX_VLD  = 1'b0;
    bus.RX_DATA = 8'h00;
    bus.TX_RDY  = 1'b1;
    repeat (3) @(negedge CLK_SYS);
    check_reset_vals("por");
    @(posedge CLK_SYS); #1;
    RST = 1'b0;
    repeat (2) @(negedge CLK_SYS);
    check("en_after_reset", 32'(bus.SKEL_EN), 32'd1);

    // writes
    exp_wr.push_back({6'd0, 16'h0300});
    send(8'h00); send(8'h03); send(8'h00);
    exp_wr.push_back({6'd1, 16'hFE00});
    send(8'h01); send(8'hFE); send(8'h00);
    drain("write_done", 50);

    // start: 3 x -2 into word 0
    exp_tx.push_back(8'h01);
    send(8'h40);
    drain("start_done", 200);
    check("trig_count_1", 32'(trig_cnt), 32'd1);

    exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFA);
    send(8'h80);
    drain("read_done", 50);

    exp_tx.push_back(8'h01); exp_tx.push_back(8'h02);
    exp_tx.push_back(8'h05); exp_tx.push_back(8'h10);
    send(8'hC0);
    drain("head_done", 50);

    // downstream stall during READ
    @(posedge CLK_SYS); #1;
    bus.TX_RDY = 1'b0;
    exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFA);
    send(8'h80);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge CLK_SYS);
        if (bus.TX_VLD) begin seen = 1'b1; break; end
      end
      check("stall_tx_vld_seen", 32'(seen), 32'd1);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK_SYS);
      check("stall_tx_vld",  32'(bus.TX_VLD),  32'd1);
      check("stall_tx_data", 32'(bus.TX_DATA), 32'hFF);
      check("stall_rx_rdy",  32'(bus.RX_RDY),  32'd0);
    end
    @(posedge CLK_SYS); #1;
    bus.TX_RDY = 1'b1;
    drain("stall_release", 50);

    // timeout: RDY never drops
    stuck = 1'b1;
    exp_tx.push_back(8'hEE);
    send(8'h40);
    drain("timeout_done", TO + 200);
    check("trig_count_2", 32'(trig_cnt), 32'd2);
    check("timeout_latency_in_range",
          32'((last_tx_cyc - last_trig_cyc) >= TO && (last_tx_cyc - last_trig_cyc) <= TO + 2),
          32'd1);
    @(negedge CLK_SYS);
    check("timeout_rx_rdy", 32'(bus.RX_RDY), 32'd1);
    stuck = 1'b0;

    // reset after the MSB of a WRITE: partial word must be discarded
    send(8'h00);
    send(8'hAA);
    #2 RST = 1'b1;
    #1 check_reset_vals("midrst");
    repeat (2) @(negedge CLK_SYS);
    check_reset_vals("midrst_hold");
    @(posedge CLK_SYS); #1;
    RST = 1'b0;
    repeat (3) @(negedge CLK_SYS);
    exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFA);
    send(8'h80);
    drain("read_after_reset", 50);
    repeat (5) @(negedge CLK_SYS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
